// File: rtl/cpu_run_pkg.sv
// Shared definitions for the processor run controller: state encoding and the
// default halt opcode.
package cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_BREAK   = 3'd3,
    ST_HALT    = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_t;

  localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFC00_0000;

endpackage

// File: rtl/bp_match_unit.sv
// Address breakpoint comparators: flags a hit when any enabled slot equals the
// current fetch address (full-width equality, no masking).
module bp_match_unit #(
  parameter int NUM_BP = 2,
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  output logic                     hit
);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_en[i] && (bp_addr[i*ADDR_W +: ADDR_W] == addr)) hit = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run-control wrapper for the single-cycle processor: reset sequencing, halt
// detection, address breakpoints, single-step and an enabled-cycle timeout.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int                  ADDR_W     = 32,
  parameter int                  INSTR_W    = 32,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = INSTR_W'(DEFAULT_HALT_INSTR),
  parameter int                  RST_CYCLES = 5,
  parameter int                  NUM_BP     = 2,
  parameter int                  CNT_W      = 32,
  parameter int                  MAX_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     step,
  input  logic [INSTR_W-1:0]       instr,
  input  logic [ADDR_W-1:0]        inst_addr,
  input  logic [NUM_BP-1:0]        bp_en,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  output logic                     pc_reset,
  output logic                     pc_enable,
  output logic [2:0]               state,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [ADDR_W-1:0]        stop_pc
);

  localparam int               RC_W       = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]  RST_LOAD   = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);

  run_state_t        state_q, state_d;
  logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] stop_pc_q, stop_pc_d;
  logic              pc_reset_q, pc_reset_d;
  logic              skip_q, skip_d;
  logic              step_q, step_d;
  logic              recap_q, recap_d;
  logic              bp_hit, halt_hit;

  bp_match_unit #(.NUM_BP(NUM_BP), .ADDR_W(ADDR_W)) u_bp (
    .addr   (inst_addr),
    .bp_en  (bp_en),
    .bp_addr(bp_addr),
    .hit    (bp_hit)
  );

  assign halt_hit = (instr == HALT_INSTR);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    skip_d    = skip_q;
    step_d    = step_q;
    recap_d   = 1'b0;
    // After an enabled cycle the PC has moved; latch where it landed.
    stop_pc_d = recap_q ? inst_addr : stop_pc_q;
    pc_enable = 1'b0;

    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_RESET;
        rst_cnt_d = RST_LOAD;
      end
      ST_RESET: begin
        cnt_d = '0;
        if (rst_cnt_q == '0) state_d = ST_RUN;
        else                 rst_cnt_d = rst_cnt_q - RC_W'(1);
      end
      ST_RUN: begin
        skip_d = 1'b0;
        step_d = 1'b0;
        if (halt_hit) begin
          state_d   = ST_HALT;
          stop_pc_d = inst_addr;
        end else if (bp_hit && !skip_q) begin
          state_d   = ST_BREAK;
          stop_pc_d = inst_addr;
        end else begin
          pc_enable = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q >= TIMEOUT_AT) begin
            state_d = ST_TIMEOUT;
            recap_d = 1'b1;
          end else if (step_q) begin
            state_d = ST_BREAK;
            recap_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        // Resuming or stepping executes the instruction sitting on the breakpoint.
        if (start) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
        end else if (step) begin
          state_d = ST_RUN;
          skip_d  = 1'b1;
          step_d  = 1'b1;
        end
      end
      ST_HALT, ST_TIMEOUT: if (start) begin
        state_d   = ST_RESET;
        rst_cnt_d = RST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    pc_reset_d = (state_d == ST_RESET);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rst_cnt_q  <= '0;
      cnt_q      <= '0;
      stop_pc_q  <= '0;
      pc_reset_q <= 1'b0;
      skip_q     <= 1'b0;
      step_q     <= 1'b0;
      recap_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      cnt_q      <= cnt_d;
      stop_pc_q  <= stop_pc_d;
      pc_reset_q <= pc_reset_d;
      skip_q     <= skip_d;
      step_q     <= step_d;
      recap_q    <= recap_d;
    end
  end

  assign pc_reset    = pc_reset_q;
  assign state       = state_q;
  assign cycle_count = cnt_q;
  assign stop_pc     = stop_pc_q;

endmodule
